// File: rtl/nn_pkg.sv
// Shared definitions for the matmul scheduler: word width, FSM encoding and
// the index-width helper used to size the row/column counters.
package nn_pkg;

    localparam int unsigned FP_W = 32;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StIssue  = 2'd1,
        StWait   = 2'd2,
        StFinish = 2'd3
    } sched_state_e;

    // Counter width for a dimension of size n; never narrower than one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/matmul_index_counter.sv
// Row-major (i,j) element counter: j runs fastest, i saturates at L-1.
// last_o flags the final element (L-1, N-1).
module matmul_index_counter
    import nn_pkg::*;
#(
    parameter int unsigned L    = 1,
    parameter int unsigned N    = 1,
    parameter int unsigned RowW = idx_w(L),
    parameter int unsigned ColW = idx_w(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr_i,
    input  logic            adv_i,
    output logic [RowW-1:0] row_o,
    output logic [ColW-1:0] col_o,
    output logic            last_o
);

    logic [RowW-1:0] row_q, row_d;
    logic [ColW-1:0] col_q, col_d;
    logic            row_last;
    logic            col_last;

    assign row_last = (row_q == RowW'(L - 1));
    assign col_last = (col_q == ColW'(N - 1));

    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (clr_i) begin
            row_d = '0;
            col_d = '0;
        end else if (adv_i) begin
            if (col_last) begin
                col_d = '0;
                if (!row_last) begin
                    row_d = row_q + RowW'(1);
                end
            end else begin
                col_d = col_q + ColW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    assign row_o  = row_q;
    assign col_o  = col_q;
    assign last_o = row_last && col_last;

endmodule

// File: rtl/matmul_seq_scheduler.sv
// Start-driven scheduler that walks one shared dot-product engine over every
// element of an LxN result. Optional dp_done watchdog: MATMUL_SCHED_TIMEOUT_EN.
module matmul_seq_scheduler
    import nn_pkg::*;
#(
    parameter int unsigned L       = 1,
    parameter int unsigned M       = 1,
    parameter int unsigned N       = 1,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [FP_W*L*M-1:0]   A,
    input  logic [FP_W*N*M-1:0]   B_T,
    output logic                  dp_start,
    output logic [FP_W*M-1:0]     dp_a,
    output logic [FP_W*M-1:0]     dp_b,
    input  logic                  dp_done,
    input  logic [FP_W-1:0]       dp_result,
    output logic [FP_W*L*N-1:0]   result,
    output logic                  busy,
    output logic                  done
`ifdef MATMUL_SCHED_TIMEOUT_EN
    ,
    output logic                  err
`endif
);

    localparam int unsigned RowBits = FP_W * M;
    localparam int unsigned RowW    = idx_w(L);
    localparam int unsigned ColW    = idx_w(N);

    sched_state_e state_q, state_d;

    logic [FP_W*L*M-1:0] a_q, a_d;
    logic [FP_W*N*M-1:0] bt_q, bt_d;
    logic [FP_W*L*N-1:0] result_q, result_d;
    logic                dp_start_q, dp_start_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic                idx_clr;
    logic                idx_adv;
    logic [RowW-1:0]     row;
    logic [ColW-1:0]     col;
    logic                idx_last;

`ifdef MATMUL_SCHED_TIMEOUT_EN
    localparam int unsigned TmoW = $clog2(TIMEOUT + 1);

    logic [TmoW-1:0] tmo_q, tmo_d;
    logic            err_q, err_d;
`endif

    matmul_index_counter #(
        .L (L),
        .N (N)
    ) u_index_counter (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (idx_clr),
        .adv_i  (idx_adv),
        .row_o  (row),
        .col_o  (col),
        .last_o (idx_last)
    );

    // Operand rows come straight from the latches, so they stay stable for the
    // whole ISSUE/WAIT window of an element and read as zero after reset.
    always_comb begin
        dp_a = '0;
        dp_b = '0;
        for (int unsigned r = 0; r < L; r++) begin
            if (row == RowW'(r)) begin
                dp_a = a_q[r*RowBits +: RowBits];
            end
        end
        for (int unsigned c = 0; c < N; c++) begin
            if (col == ColW'(c)) begin
                dp_b = bt_q[c*RowBits +: RowBits];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        bt_d       = bt_q;
        result_d   = result_q;
        dp_start_d = 1'b0;
        busy_d     = busy_q;
        done_d     = done_q;
        idx_clr    = 1'b0;
        idx_adv    = 1'b0;
`ifdef MATMUL_SCHED_TIMEOUT_EN
        tmo_d      = tmo_q;
        err_d      = err_q;
`endif

        case (state_q)
            StIdle, StFinish: begin
                if (start) begin
                    a_d        = A;
                    bt_d       = B_T;
                    result_d   = '0;
                    idx_clr    = 1'b1;
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
                    dp_start_d = 1'b1;
                    state_d    = StIssue;
`ifdef MATMUL_SCHED_TIMEOUT_EN
                    err_d      = 1'b0;
`endif
                end
            end

            StIssue: begin
                state_d = StWait;
`ifdef MATMUL_SCHED_TIMEOUT_EN
                tmo_d   = '0;
`endif
            end

            StWait: begin
                if (dp_done) begin
                    for (int unsigned r = 0; r < L; r++) begin
                        for (int unsigned c = 0; c < N; c++) begin
                            if (row == RowW'(r) && col == ColW'(c)) begin
                                result_d[(r*N+c)*FP_W +: FP_W] = dp_result;
                            end
                        end
                    end
                    idx_adv = 1'b1;
                    if (idx_last) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = StFinish;
                    end else begin
                        dp_start_d = 1'b1;
                        state_d    = StIssue;
                    end
                end
`ifdef MATMUL_SCHED_TIMEOUT_EN
                else if (tmo_q == TmoW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = StFinish;
                end else begin
                    tmo_d = tmo_q + TmoW'(1);
                end
`endif
            end

            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            a_q        <= '0;
            bt_q       <= '0;
            result_q   <= '0;
            dp_start_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef MATMUL_SCHED_TIMEOUT_EN
            tmo_q      <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            bt_q       <= bt_d;
            result_q   <= result_d;
            dp_start_q <= dp_start_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
`ifdef MATMUL_SCHED_TIMEOUT_EN
            tmo_q      <= tmo_d;
            err_q      <= err_d;
`endif
        end
    end

    assign dp_start = dp_start_q;
    assign result   = result_q;
    assign busy     = busy_q;
    assign done     = done_q;
`ifdef MATMUL_SCHED_TIMEOUT_EN
    assign err      = err_q;
`endif

endmodule

// File: tb/tb_matmul_seq_scheduler.sv
// Self-checking bench for matmul_seq_scheduler (L=M=N=2) with a stub engine of
// configurable latency; watchdog scenario runs when MATMUL_SCHED_TIMEOUT_EN is set.
module tb_matmul_seq_scheduler;

    localparam int unsigned L       = 2;
    localparam int unsigned M       = 2;
    localparam int unsigned N       = 2;
    localparam int unsigned TIMEOUT = 8;
    localparam int unsigned FP      = 32;

    logic                clk = 1'b0;
    logic                rst;
    logic                start;
    logic [FP*L*M-1:0]   A;
    logic [FP*N*M-1:0]   B_T;
    logic                dp_start;
    logic [FP*M-1:0]     dp_a;
    logic [FP*M-1:0]     dp_b;
    logic                dp_done   = 1'b0;
    logic [FP-1:0]       dp_result = '0;
    logic [FP*L*N-1:0]   result;
    logic                busy;
    logic                done;
`ifdef MATMUL_SCHED_TIMEOUT_EN
    logic                err;
`endif

    always #5 clk = ~clk;

    matmul_seq_scheduler #(
        .L       (L),
        .M       (M),
        .N       (N),
        .TIMEOUT (TIMEOUT)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .A         (A),
        .B_T       (B_T),
        .dp_start  (dp_start),
        .dp_a      (dp_a),
        .dp_b      (dp_b),
        .dp_done   (dp_done),
        .dp_result (dp_result),
        .result    (result),
        .busy      (busy),
        .done      (done)
`ifdef MATMUL_SCHED_TIMEOUT_EN
        ,
        .err       (err)
`endif
    );

    int checks = 0;
    int errors = 0;

    logic [FP*M-1:0]   q_a[$];
    logic [FP*M-1:0]   q_b[$];
    logic [FP*L*N-1:0] exp_result;

    int unsigned stub_k   = 2;
    bit          stub_en  = 1'b1;
    int unsigned stub_cnt = 0;

    // Stub engine: dp_done arrives K cycles after the dp_start cycle.
    always @(negedge clk) begin
        if (dp_done) dp_done = 1'b0;
        if (dp_start && stub_en) begin
            stub_cnt = stub_k;
        end else if (stub_cnt > 0) begin
            stub_cnt = stub_cnt - 1;
            if (stub_cnt == 0) begin
                dp_done   = 1'b1;
                dp_result = 32'h3F80_0000 + dp_a[FP-1:0] + dp_b[FP-1:0];
            end
        end
    end

    // Drives new operands plus start (caller is already on a negedge) and
    // pushes the expected operand rows in row-major element order.
    task automatic start_job(input logic [31:0] base);
        for (int r = 0; r < int'(L); r++)
            for (int w = 0; w < int'(M); w++)
                A[(r*M+w)*FP +: FP] = (w == 0) ? base + 32'(4 * N * r) : $urandom;
        for (int c = 0; c < int'(N); c++)
            for (int w = 0; w < int'(M); w++)
                B_T[(c*M+w)*FP +: FP] = (w == 0) ? 32'(4 * c) : $urandom;
        for (int r = 0; r < int'(L); r++) begin
            for (int c = 0; c < int'(N); c++) begin
                q_a.push_back(A[r*M*FP +: M*FP]);
                q_b.push_back(B_T[c*M*FP +: M*FP]);
                exp_result[(r*N+c)*FP +: FP] =
                    32'h3F80_0000 + A[r*M*FP +: FP] + B_T[c*M*FP +: FP];
            end
        end
        start = 1'b1;
    endtask

    // Runs cycles until done rises (or budget expires), popping the scoreboard
    // on every dp_start. poke_cyc>0 re-pulses start with scrambled A mid-job.
    task automatic wait_job(input int budget, input int poke_cyc, output int done_cyc,
                            output int first_start, output int pulses, output bit busy_ok,
                            output bit c1_done, output bit c1_busy, output bit c1_res_zero);
        logic [FP*M-1:0] ea, eb;
        done_cyc = 0; first_start = 0; pulses = 0; busy_ok = 1'b1;
        c1_done = 1'b1; c1_busy = 1'b0; c1_res_zero = 1'b0;
        for (int cyc = 1; cyc <= budget; cyc++) begin
            @(negedge clk);
            start = (cyc == poke_cyc);
            if (cyc == poke_cyc) A = ~A;
            if (cyc == 1) begin
                c1_done = done; c1_busy = busy; c1_res_zero = (result === '0);
            end
            if (dp_start) begin
                pulses++;
                if (first_start == 0) first_start = cyc;
                checks++;
                if (q_a.size() == 0) begin
                    errors++;
                    $display("FAIL scoreboard_pop: got unexpected dp_start at cycle %0d", cyc);
                end else begin
                    ea = q_a.pop_front();
                    eb = q_b.pop_front();
                    if (dp_a !== ea || dp_b !== eb) begin
                        errors++;
                        $display("FAIL dp_operands: got a=%h b=%h, expected a=%h b=%h",
                                 dp_a, dp_b, ea, eb);
                    end
                end
            end
            if (done === 1'b1) begin
                done_cyc = cyc;
                break;
            end
            if (busy !== 1'b1) busy_ok = 1'b0;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; A = '0; B_T = '0;
        repeat (3) @(negedge clk);
        checks++; if (dp_start !== 1'b0) begin errors++; $display("FAIL reset_dp_start: got %b expected 0", dp_start); end
        checks++; if (dp_a !== '0) begin errors++; $display("FAIL reset_dp_a: got %h expected 0", dp_a); end
        checks++; if (dp_b !== '0) begin errors++; $display("FAIL reset_dp_b: got %h expected 0", dp_b); end
        checks++; if (result !== '0) begin errors++; $display("FAIL reset_result: got %h expected 0", result); end
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_busy_done: got %b%b expected 00", busy, done); end
`ifdef MATMUL_SCHED_TIMEOUT_EN
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
`endif
        rst = 1'b0;
    endtask

    task automatic test_single_job();
        int dc, fs, np; bit bok, c1d, c1b, c1z;
        stub_k = 2;
        @(negedge clk);
        start_job(32'h0);
        wait_job(60, 0, dc, fs, np, bok, c1d, c1b, c1z);
        checks++; if (fs != 1) begin errors++; $display("FAIL single_first_dp_start: got cycle %0d expected 1", fs); end
        checks++; if (dc != 13) begin errors++; $display("FAIL single_done_cycle: got %0d expected 13", dc); end
        checks++; if (np != 4) begin errors++; $display("FAIL single_pulses: got %0d expected 4", np); end
        checks++; if (result !== exp_result) begin errors++; $display("FAIL single_result: got %h expected %h", result, exp_result); end
        checks++; if (busy !== 1'b0 || !bok) begin errors++; $display("FAIL single_busy: got busy=%b held=%b expected 0/1", busy, bok); end
    endtask

    task automatic test_latency();
        int dc, fs, np; bit bok, c1d, c1b, c1z;
        int unsigned ks[2] = '{1, 3};
        foreach (ks[n]) begin
            stub_k = ks[n];
            @(negedge clk);
            start_job(32'h100 * ks[n]);
            wait_job(80, 0, dc, fs, np, bok, c1d, c1b, c1z);
            checks++;
            if (dc != int'(L * N * (ks[n] + 1) + 1)) begin
                errors++;
                $display("FAIL latency_done_cycle K=%0d: got %0d expected %0d", ks[n], dc, L * N * (ks[n] + 1) + 1);
            end
            checks++; if (result !== exp_result) begin errors++; $display("FAIL latency_result K=%0d: got %h expected %h", ks[n], result, exp_result); end
            checks++; if (c1d !== 1'b0) begin errors++; $display("FAIL latency_done_cleared K=%0d: got %b expected 0", ks[n], c1d); end
        end
    endtask

    task automatic test_start_while_busy();
        int dc, fs, np; bit bok, c1d, c1b, c1z;
        stub_k = 2;
        @(negedge clk);
        start_job(32'h40);
        wait_job(60, 5, dc, fs, np, bok, c1d, c1b, c1z);
        checks++; if (dc != 13 || np != 4) begin errors++; $display("FAIL busy_start_ignored: got done=%0d pulses=%0d expected 13/4", dc, np); end
        checks++; if (result !== exp_result) begin errors++; $display("FAIL busy_result_latched: got %h expected %h", result, exp_result); end
        checks++; if (!bok) begin errors++; $display("FAIL busy_held: got busy drop before done, expected held"); end
    endtask

    task automatic test_reset_mid_job();
        int np = 0; bit seen = 1'b0; bit nonzero = 1'b0;
        logic [FP*M-1:0] ea, eb;
        stub_k = 6;
        @(negedge clk);
        start_job(32'h20);
        for (int cyc = 1; cyc <= 60 && np < 3; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (dp_start) begin
                np++;
                ea = q_a.pop_front(); eb = q_b.pop_front();
                checks++;
                if (dp_a !== ea || dp_b !== eb) begin
                    errors++;
                    $display("FAIL rstmid_operands: got a=%h b=%h expected a=%h b=%h", dp_a, dp_b, ea, eb);
                end
            end
        end
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        q_a.delete(); q_b.delete();
        checks++;
        if (dp_start !== 1'b0 || dp_a !== '0 || dp_b !== '0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_outputs: got st=%b a=%h b=%h busy=%b done=%b expected all 0", dp_start, dp_a, dp_b, busy, done);
        end
        checks++; if (result !== '0) begin errors++; $display("FAIL rstmid_result: got %h expected 0", result); end
        repeat (10) begin
            @(negedge clk);
            if (dp_start) seen = 1'b1;
            if (result !== '0 || done !== 1'b0) nonzero = 1'b1;
        end
        checks++; if (seen || nonzero) begin errors++; $display("FAIL rstmid_idle: got dp_start=%b write=%b expected 0/0", seen, nonzero); end
    endtask

    task automatic test_back_to_back();
        int dc, fs, np; bit bok, c1d, c1b, c1z;
        stub_k = 2;
        @(negedge clk);
        start_job(32'h80);
        wait_job(60, 0, dc, fs, np, bok, c1d, c1b, c1z);
        checks++; if (result !== exp_result) begin errors++; $display("FAIL b2b_first_result: got %h expected %h", result, exp_result); end
        start_job(32'hC0);
        wait_job(60, 0, dc, fs, np, bok, c1d, c1b, c1z);
        checks++; if (c1d !== 1'b0 || c1b !== 1'b1) begin errors++; $display("FAIL b2b_handshake: got done=%b busy=%b expected 0/1", c1d, c1b); end
        checks++; if (!c1z) begin errors++; $display("FAIL b2b_result_cleared: got nonzero expected 0"); end
        checks++; if (fs != 1 || dc != 13) begin errors++; $display("FAIL b2b_timing: got start=%0d done=%0d expected 1/13", fs, dc); end
        checks++; if (result !== exp_result) begin errors++; $display("FAIL b2b_second_result: got %h expected %h", result, exp_result); end
    endtask

`ifdef MATMUL_SCHED_TIMEOUT_EN
    task automatic test_timeout();
        int dc, fs, np; bit bok, c1d, c1b, c1z;
        stub_en = 1'b0;
        @(negedge clk);
        start_job(32'h0);
        wait_job(40, 0, dc, fs, np, bok, c1d, c1b, c1z);
        q_a.delete(); q_b.delete();
        checks++; if (fs != 1 || dc != 10) begin errors++; $display("FAIL tmo_timing: got start=%0d done=%0d expected 1/10", fs, dc); end
        checks++; if (err !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL tmo_err: got err=%b busy=%b expected 1/0", err, busy); end
        checks++; if (result !== '0) begin errors++; $display("FAIL tmo_result: got %h expected 0", result); end
        stub_en = 1'b1;
        start_job(32'h10);
        wait_job(60, 0, dc, fs, np, bok, c1d, c1b, c1z);
        checks++; if (err !== 1'b0 || result !== exp_result) begin errors++; $display("FAIL tmo_recover: got err=%b result=%h expected 0/%h", err, result, exp_result); end
    endtask
`endif

    initial begin
        test_reset();
        test_single_job();
        test_latency();
        test_start_while_busy();
        test_reset_mid_job();
        test_back_to_back();
`ifdef MATMUL_SCHED_TIMEOUT_EN
        test_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
